// File: rtl/tile_map_renderer_if.sv
// tile_map_renderer_if
// Groups the raster input, CPU write port, texture ROM link and colour output
// of the tile map renderer. The renderer takes the slave side. The raster
// source, the CPU and the ROM together take the master side.
interface tile_map_renderer_if;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic        pix_de;
   logic        frame_start;
   logic        wr_en;
   logic [11:0] wr_addr;
   logic [9:0]  wr_data;
   logic [5:0]  texture_idx;
   logic [2:0]  y_idx;
   logic [2:0]  x_idx;
   logic [2:0]  tex_val;
   logic [2:0]  color;
   logic        color_de;

   modport master (
      output pix_x, pix_y, pix_de, frame_start, wr_en, wr_addr, wr_data, tex_val,
      input  texture_idx, y_idx, x_idx, color, color_de
   );

   modport slave (
      input  pix_x, pix_y, pix_de, frame_start, wr_en, wr_addr, wr_data, tex_val,
      output texture_idx, y_idx, x_idx, color, color_de
   );
endinterface

// File: rtl/tile_map_renderer.sv
// tile_map_renderer
// Converts raster coordinates into tile map and texture ROM lookups.
// The pipeline is three stages: map read, ROM sample, colour. Its latency from
// pix_* to color/color_de is 3 clk.
// Optional feature macro: TILE_MAP_SCROLL_EN. Defining it adds frame-synchronous
// scroll registers and modulo coordinate wrap. Without it, the map is drawn
// unscrolled.
module tile_map_renderer (
   input  logic clk,
   input  logic reset,
   tile_map_renderer_if.slave bus
);
   localparam int MAP_COLS = 40;
   localparam int MAP_ROWS = 30;
   localparam int MAP_SIZE = MAP_COLS * MAP_ROWS;
   localparam logic [10:0] H_ACTIVE = 11'd640;
   localparam logic [10:0] V_ACTIVE = 11'd480;

   logic [5:0]  map_ram [0:MAP_SIZE-1];
   logic [9:0]  ex;
   logic [9:0]  ey;
   logic [4:0]  tile_row;
   logic [5:0]  tile_col;
   logic [10:0] tile_addr;
   logic        map_wr;

   logic [5:0]  texture_idx_q;
   logic [2:0]  x_idx_q;
   logic [2:0]  y_idx_q;
   logic        de1;
   logic        de2;
   logic [2:0]  color_q;
   logic        color_de_q;

`ifdef TILE_MAP_SCROLL_EN
   logic [9:0]  sx;
   logic [9:0]  sy;
   logic [9:0]  sx_p;
   logic [9:0]  sy_p;
   logic [10:0] sum_x;
   logic [10:0] sum_y;

   // Pending scroll values are clamped on write. Active values change only at frame_start, so a frame never tears.
   always_ff @(posedge clk) begin
      if (reset) begin
         sx_p <= 10'd0;
         sy_p <= 10'd0;
         sx   <= 10'd0;
         sy   <= 10'd0;
      end else begin
         if (bus.wr_en && bus.wr_addr == 12'h800)
            sx_p <= (bus.wr_data >= 10'(H_ACTIVE)) ? 10'(H_ACTIVE - 11'd1) : bus.wr_data;
         if (bus.wr_en && bus.wr_addr == 12'h801)
            sy_p <= (bus.wr_data >= 10'(V_ACTIVE)) ? 10'(V_ACTIVE - 11'd1) : bus.wr_data;
         if (bus.frame_start) begin
            sx <= sx_p;
            sy <= sy_p;
         end
      end
   end

   // Scrolled coordinates wrap modulo the visible area. A single subtract is enough because both operands are in range.
   always_comb begin
      sum_x = {1'b0, bus.pix_x} + {1'b0, sx};
      sum_y = {1'b0, bus.pix_y} + {1'b0, sy};
      ex = (sum_x >= H_ACTIVE) ? 10'(sum_x - H_ACTIVE) : sum_x[9:0];
      ey = (sum_y >= V_ACTIVE) ? 10'(sum_y - V_ACTIVE) : sum_y[9:0];
   end

   logic unused_bits;
   assign unused_bits = ^{ex[0], ey[9], ey[0]};
`else
   // Without scrolling, the map is addressed directly by the raster position.
   always_comb begin
      ex = bus.pix_x;
      ey = bus.pix_y;
   end

   logic unused_bits;
   assign unused_bits = ^{ex[0], ey[9], ey[0], bus.frame_start, bus.wr_data[9:6]};
`endif

   // Tile address is row*40 + col, built from shifts: row*32 + row*8.
   always_comb begin
      tile_row  = ey[8:4];
      tile_col  = ex[9:4];
      tile_addr = 11'({tile_row, 5'b0}) + 11'({tile_row, 3'b0}) + 11'(tile_col);
      map_wr    = bus.wr_en && (bus.wr_addr < 12'(MAP_SIZE));
   end

   // CPU write port of the map RAM. The read port below runs in parallel, so it still sees the old data for that edge.
   always_ff @(posedge clk) begin
      if (map_wr)
         map_ram[bus.wr_addr[10:0]] <= bus.wr_data[5:0];
   end

   // The three-stage pixel pipeline. ROM address fields hold their value outside the visible area.
   always_ff @(posedge clk) begin
      if (reset) begin
         texture_idx_q <= 6'd0;
         x_idx_q       <= 3'd0;
         y_idx_q       <= 3'd0;
         de1           <= 1'b0;
         de2           <= 1'b0;
         color_q       <= 3'd0;
         color_de_q    <= 1'b0;
      end else begin
         de1 <= bus.pix_de;
         if (bus.pix_de) begin
            texture_idx_q <= map_ram[tile_addr];
            x_idx_q       <= ex[3:1];
            y_idx_q       <= ey[3:1];
         end
         de2        <= de1;
         color_q    <= de2 ? bus.tex_val : 3'd0;
         color_de_q <= de2;
      end
   end

   assign bus.texture_idx = texture_idx_q;
   assign bus.x_idx       = x_idx_q;
   assign bus.y_idx       = y_idx_q;
   assign bus.color       = color_q;
   assign bus.color_de    = color_de_q;
endmodule

// File: doc/tile_map_renderer.md
# tile_map_renderer

Per-pixel background renderer that turns VGA raster coordinates into texture ROM lookups and delivers a 3-bit pixel value to the colour output stage. It holds a 40x30 tile map of 6-bit texture indices (each tile is one 8x8 texture drawn at 2x scale, 16x16 screen pixels) and drives the texture ROM address fields directly. It consumes the ROM's registered 3-bit result. Sits between the VGA timing generator and the palette/DAC stage; the CPU writes the map and scroll registers through a simple write port.

## Interface
- MAP_COLS, 40, tiles per row (640/16)
- MAP_ROWS, 30, tile rows (480/16)
- H_ACTIVE, 640, visible width in pixels
- V_ACTIVE, 480, visible height in pixels

- clk  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- pix_x  in  10  current raster column
- pix_y  in  10  current raster row
- pix_de  in  1  raster in visible area
- frame_start  in  1  one-cycle pulse at start of vertical blank
- wr_en  in  1  CPU write strobe
- wr_addr  in  12  0x000-0x4AF map entry (row*40+col); 0x800 scroll_x; 0x801 scroll_y
- wr_data  in  10  write data (map uses [5:0])
- texture_idx  out  6  to texture ROM
- y_idx  out  3  to texture ROM
- x_idx  out  3  to texture ROM
- tex_val  in  3  registered ROM output, valid one cycle after address
- color  out  3  rendered pixel value
- color_de  out  1  color valid (delayed pix_de)

## Operation
- Scroll: pending registers sx_p, sy_p written via wr_addr 0x800/0x801; active sx, sy load from pending on frame_start only. Mid-frame scroll writes never tear a frame.
- Effective coords: ex = pix_x + sx; if ex >= 640, subtract 640. ey likewise modulo 480. Scroll values written >= 640 (x) or >= 480 (y) are clamped to 639 / 479 at write time.
- Tile address = (ey>>4)*40 + (ex>>4), range 0-1199; texel x = ex[3:1], texel y = ey[3:1].
- Map RAM: 1200x6, one synchronous read port (raster), one write port (CPU). Same-cycle read and write to the same address returns OLD data. Writes to 0x4B0-0x7FF and 0x802-0xFFF are ignored.
- Pipeline stages:
  - S1: map read issued, texel coords and pix_de registered.
  - S2: texture_idx = map data, x_idx/y_idx = S1 coords; ROM samples.
  - S3: color <= tex_val when S2 de, else 0; color_de <= S2 de.
- Outside the visible area, ROM addresses hold their last value. color is forced to 0.

## Timing
- Latency pix_x/pix_y/pix_de -> color/color_de: exactly 3 clk. Fully pipelined, one pixel per clk, no stalls.
- texture_idx/x_idx/y_idx are registered outputs, valid 1 clk after inputs.
- Reset values: texture_idx=0, x_idx=0, y_idx=0, color=0, color_de=0, sx=sy=sx_p=sy_p=0. Map RAM contents are not reset.
- Reset mid-line: all pipeline valid flags clear the same edge. color_de stays 0 until 3 clk after the first de after reset release.
- frame_start and a scroll write in the same cycle: the active register loads the OLD pending value. The new value applies at the next frame_start.
- Wrap-around: ex=639 -> tile col 39, x_idx 7. The next pixel with carry past 640 -> col 0, x_idx 0.

## Configuration
- TILE_MAP_SCROLL_EN defined: scroll registers, frame_start latch and modulo adders present as above.
- Undefined: sx=sy=0 constant, ex=pix_x, ey=pix_y. Writes to 0x800/0x801 are ignored and frame_start is unused. Latency stays 3 clk.

## Test plan
- Map entry 0 = 0x05, scroll 0, ROM model returning {x_idx} -> at pix (0..15, 0): texture_idx=5 one clk later; color sequence 0,0,1,1,...,7,7 after 3 clk.
- Write map[1199]=0x3F, raster (639,479) -> texture_idx=0x3F, x_idx=7, y_idx=7.
- Write scroll_x=8 mid-frame, pulse frame_start -> pix_x=632 reads tile col 0, x_idx 0. Before the pulse, pix_x=632 reads col 39, x_idx 4.
- Scroll write and frame_start in same cycle -> active scroll unchanged until the following frame_start.
- Simultaneous CPU write and raster read of map[0] (old 0x01, new 0x02) -> texture_idx=0x01 that pixel, 0x02 on next read.
- Assert reset for 1 clk mid-line with pix_de=1 -> color=0, color_de=0 for the next 3 clk, then resume. Check both with and without TILE_MAP_SCROLL_EN.
